// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: forwarding select
// codes, stall FSM state encoding and producer/consumer helper functions.
package pipe_hazard_ctrl_pkg;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // value read from the register file (IDReg busA/busB)
    FWD_MEM = 2'b01,  // EX/MEM ALU result
    FWD_WB  = 2'b10   // MEM/WB write-back data
  } fwd_sel_e;

  // Stall FSM states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Width of the remaining-stall-cycles down-counter
  localparam int LEFT_W = 3;

  // Control bits carried in IDReg; a bubble loads all of them as zero
  typedef struct packed {
    logic       regwr;
    logic       memtoreg;
    logic       memwr;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic       regdst;
    logic [2:0] aluop;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  // A producer only matters if it really writes a non-zero register and
  // its result was not suppressed by an arithmetic overflow.
  function automatic logic producer_valid(input logic       regwr,
                                          input logic [4:0] rw,
                                          input logic       ovf);
    return regwr && (rw != 5'd0) && !ovf;
  endfunction

  // True if the ID instruction reads register rw (Rt only when it is used).
  function automatic logic id_reads(input logic [4:0] rw,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       rt_used);
    return (rw == rs) || (rt_used && (rw == rt));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX-stage ALU operand. The nearer producer
// (EX/MEM) wins over the older one (MEM/WB) because it holds newer data.
module pipe_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [4:0] ex_src,
  input  logic       mem_valid,
  input  logic [4:0] mem_rw,
  input  logic       wb_valid,
  input  logic [4:0] wb_rw,
  output logic [1:0] sel
);

  // Pick the newest valid producer of the operand register
  always_comb begin
    sel = FWD_RF;
    if (FWD_EN != 0) begin
      if (mem_valid && (mem_rw == ex_src)) begin
        sel = FWD_MEM;
      end else if (wb_valid && (wb_rw == ex_src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: EX operand forwarding,
// WB->ID bypass, RAW stall FSM, redirect flushing and perf counters.
// All control outputs are combinational in the current cycle; only the
// FSM state, the stall down-counter and the counters are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN     = 1,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rt_used,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwr,
  input  logic             ex_memtoreg,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regwr,
  input  logic             mem_ovf,
  input  logic             mem_redirect,
  input  logic [4:0]       wb_rw,
  input  logic             wb_regwr,
  input  logic             wb_ovf,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Load-use stall length, clamped to what the down-counter can express
  localparam logic [LEFT_W-1:0] LOAD_STALL_C =
    (LOAD_STALL < 1) ? LEFT_W'(1) :
    (LOAD_STALL > 7) ? LEFT_W'(7) : LEFT_W'(LOAD_STALL);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_reg, state_next;
  logic [LEFT_W-1:0]   left_reg, left_next;
  logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0]    flush_cnt_reg, flush_cnt_next;

  logic                ex_valid;
  logic                mem_valid;
  logic                wb_valid;
  logic                ex_hit;
  logic                mem_hit;
  logic                wb_hit;
  logic [LEFT_W-1:0]   haz_cnt;
  logic                hold_c;
  logic                flush_c;

  logic [4:0]          opnd_src [2];
  logic [1:0]          opnd_sel [2];

  // Producer validity; the EX instruction has no overflow flag yet
  assign ex_valid  = producer_valid(ex_regwr, ex_rw, 1'b0);
  assign mem_valid = producer_valid(mem_regwr, mem_rw, mem_ovf);
  assign wb_valid  = producer_valid(wb_regwr, wb_rw, wb_ovf);

  // Does the instruction in ID read what each stage is about to write
  assign ex_hit  = ex_valid  && id_reads(ex_rw,  id_rs, id_rt, id_rt_used);
  assign mem_hit = mem_valid && id_reads(mem_rw, id_rs, id_rt, id_rt_used);
  assign wb_hit  = wb_valid  && id_reads(wb_rw,  id_rs, id_rt, id_rt_used);

  // Operand A compares against Rs, operand B against Rt
  assign opnd_src[0] = ex_rs;
  assign opnd_src[1] = ex_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      pipe_fwd_sel #(
        .FWD_EN (FWD_EN)
      ) u_fwd_sel (
        .ex_src    (opnd_src[gi]),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .wb_valid  (wb_valid),
        .wb_rw     (wb_rw),
        .sel       (opnd_sel[gi])
      );
    end
  endgenerate

  // Hazard length seen by a new ID instruction; only evaluated in RUN.
  // Without forwarding the wait is set by how far the producer still has
  // to travel before its value reaches the register file.
  always_comb begin
    haz_cnt = '0;
    if (state_reg == ST_RUN) begin
      if (FWD_EN != 0) begin
        if (ex_memtoreg && ex_hit) begin
          haz_cnt = LOAD_STALL_C;
        end
      end else begin
        if (ex_hit) begin
          haz_cnt = LEFT_W'(3);
        end else if (mem_hit) begin
          haz_cnt = LEFT_W'(2);
        end else if (wb_hit) begin
          haz_cnt = LEFT_W'(1);
        end
      end
    end
  end

  // Stall FSM next state; a redirect overrides any stall in progress
  always_comb begin
    state_next = state_reg;
    left_next  = left_reg;
    hold_c     = 1'b0;
    flush_c    = 1'b0;
    if (mem_redirect) begin
      flush_c    = 1'b1;
      state_next = ST_RUN;
      left_next  = '0;
    end else if (state_reg == ST_STALL) begin
      if (left_reg == '0) begin
        // Defensive exit; STALL is normally left when left reaches 0
        state_next = ST_RUN;
      end else begin
        hold_c    = 1'b1;
        left_next = left_reg - LEFT_W'(1);
        if (left_reg == LEFT_W'(1)) begin
          state_next = ST_RUN;
        end
      end
    end else if (haz_cnt != '0) begin
      hold_c    = 1'b1;
      left_next = haz_cnt - LEFT_W'(1);
      if (haz_cnt > LEFT_W'(1)) begin
        state_next = ST_STALL;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (hold_c && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + CNT_ONE;
    end
    if (mem_redirect && (flush_cnt_reg != '1)) begin
      flush_cnt_next = flush_cnt_reg + CNT_ONE;
    end
  end

  // State and counter registers; reset abandons any stall in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      left_reg      <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      left_reg      <= left_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Control outputs are forced quiet while reset is held
  assign pc_hold     = !rst && hold_c;
  assign ifid_hold   = !rst && hold_c;
  assign idex_bubble = !rst && hold_c;
  assign flush_if    = !rst && flush_c;
  assign flush_id    = !rst && flush_c;
  assign flush_ex    = !rst && flush_c;
  assign fwd_a       = rst ? FWD_RF : opnd_sel[0];
  assign fwd_b       = rst ? FWD_RF : opnd_sel[1];
  assign id_byp_a    = !rst && wb_valid && (wb_rw == id_rs);
  assign id_byp_b    = !rst && wb_valid && id_rt_used && (wb_rw == id_rt);
  assign stalled     = !rst && (state_reg == ST_STALL);
  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations driven by shared
// stimulus (forwarding/1-cycle load stall, no forwarding, forwarding with
// 3-cycle load stall and 4-bit counters). A reference model pushes the
// expected response per cycle; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int NCFG = 3;
  localparam int CFG_FWD [NCFG] = '{1, 0, 1};
  localparam int CFG_LS  [NCFG] = '{1, 1, 3};
  localparam int CFG_CW  [NCFG] = '{32, 32, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw;
  logic       id_rt_used, ex_regwr, ex_memtoreg;
  logic       mem_regwr, mem_ovf, mem_redirect, wb_regwr, wb_ovf;

  logic [NCFG-1:0] pc_hold_v, ifid_hold_v, idex_bubble_v;
  logic [NCFG-1:0] flush_if_v, flush_id_v, flush_ex_v;
  logic [NCFG-1:0] id_byp_a_v, id_byp_b_v, stalled_v;
  logic [1:0]      fwd_a_v [NCFG];
  logic [1:0]      fwd_b_v [NCFG];
  logic [31:0]     stall_cnt_w [2];
  logic [31:0]     flush_cnt_w [2];
  logic [3:0]      stall_cnt_s, flush_cnt_s;

  pipe_hazard_ctrl #(.FWD_EN(1), .LOAD_STALL(1), .CNT_W(32)) u_dut_fwd (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw), .mem_regwr(mem_regwr), .mem_ovf(mem_ovf), .mem_redirect(mem_redirect),
    .wb_rw(wb_rw), .wb_regwr(wb_regwr), .wb_ovf(wb_ovf),
    .pc_hold(pc_hold_v[0]), .ifid_hold(ifid_hold_v[0]), .idex_bubble(idex_bubble_v[0]),
    .flush_if(flush_if_v[0]), .flush_id(flush_id_v[0]), .flush_ex(flush_ex_v[0]),
    .fwd_a(fwd_a_v[0]), .fwd_b(fwd_b_v[0]), .id_byp_a(id_byp_a_v[0]), .id_byp_b(id_byp_b_v[0]),
    .stalled(stalled_v[0]), .stall_cnt(stall_cnt_w[0]), .flush_cnt(flush_cnt_w[0])
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .LOAD_STALL(1), .CNT_W(32)) u_dut_nofwd (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw), .mem_regwr(mem_regwr), .mem_ovf(mem_ovf), .mem_redirect(mem_redirect),
    .wb_rw(wb_rw), .wb_regwr(wb_regwr), .wb_ovf(wb_ovf),
    .pc_hold(pc_hold_v[1]), .ifid_hold(ifid_hold_v[1]), .idex_bubble(idex_bubble_v[1]),
    .flush_if(flush_if_v[1]), .flush_id(flush_id_v[1]), .flush_ex(flush_ex_v[1]),
    .fwd_a(fwd_a_v[1]), .fwd_b(fwd_b_v[1]), .id_byp_a(id_byp_a_v[1]), .id_byp_b(id_byp_b_v[1]),
    .stalled(stalled_v[1]), .stall_cnt(stall_cnt_w[1]), .flush_cnt(flush_cnt_w[1])
  );

  pipe_hazard_ctrl #(.FWD_EN(1), .LOAD_STALL(3), .CNT_W(4)) u_dut_ls3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw), .mem_regwr(mem_regwr), .mem_ovf(mem_ovf), .mem_redirect(mem_redirect),
    .wb_rw(wb_rw), .wb_regwr(wb_regwr), .wb_ovf(wb_ovf),
    .pc_hold(pc_hold_v[2]), .ifid_hold(ifid_hold_v[2]), .idex_bubble(idex_bubble_v[2]),
    .flush_if(flush_if_v[2]), .flush_id(flush_id_v[2]), .flush_ex(flush_ex_v[2]),
    .fwd_a(fwd_a_v[2]), .fwd_b(fwd_b_v[2]), .id_byp_a(id_byp_a_v[2]), .id_byp_b(id_byp_b_v[2]),
    .stalled(stalled_v[2]), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  // Control word layout:
  // {pc_hold, ifid_hold, idex_bubble, flush_if, flush_id, flush_ex, fwd_a, fwd_b, byp_a, byp_b, stalled}
  typedef struct {
    int          cfg;
    int          trans;
    logic [12:0] ctrl;
    longint      scnt;
    longint      fcnt;
  } exp_t;

  exp_t   sbq [$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     trans_n = 0;

  // Reference model state: cycles of hold still owed, and counter values
  int     rem    [NCFG] = '{0, 0, 0};
  longint m_scnt [NCFG] = '{0, 0, 0};
  longint m_fcnt [NCFG] = '{0, 0, 0};

  function automatic logic [12:0] dut_ctrl(input int c);
    return {pc_hold_v[c], ifid_hold_v[c], idex_bubble_v[c], flush_if_v[c], flush_id_v[c],
            flush_ex_v[c], fwd_a_v[c], fwd_b_v[c], id_byp_a_v[c], id_byp_b_v[c], stalled_v[c]};
  endfunction

  function automatic longint dut_scnt(input int c);
    if (c == 2) return longint'(stall_cnt_s);
    return longint'(stall_cnt_w[c]);
  endfunction

  function automatic longint dut_fcnt(input int c);
    if (c == 2) return longint'(flush_cnt_s);
    return longint'(flush_cnt_w[c]);
  endfunction

  function automatic bit writes(input logic wr, input logic [4:0] rw, input logic ovf);
    return wr && (rw != 5'd0) && !ovf;
  endfunction

  function automatic bit id_needs(input logic [4:0] rw);
    return (rw == id_rs) || (id_rt_used && (rw == id_rt));
  endfunction

  // Hold cycles a new ID instruction must wait for its operands
  function automatic int wait_cycles(input int c);
    if (CFG_FWD[c] != 0) begin
      if (ex_memtoreg && writes(ex_regwr, ex_rw, 1'b0) && id_needs(ex_rw)) return CFG_LS[c];
      return 0;
    end
    // No forwarding: wait until the producer has written back (WB is 3 stages ahead of ID)
    if (writes(ex_regwr, ex_rw, 1'b0) && id_needs(ex_rw)) return 3;
    if (writes(mem_regwr, mem_rw, mem_ovf) && id_needs(mem_rw)) return 2;
    if (writes(wb_regwr, wb_rw, wb_ovf) && id_needs(wb_rw)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] operand_src(input int c, input logic [4:0] r);
    if (CFG_FWD[c] == 0) return 2'd0;
    if (writes(mem_regwr, mem_rw, mem_ovf) && mem_rw == r) return 2'd1;
    if (writes(wb_regwr, wb_rw, wb_ovf) && wb_rw == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_cycle(input int c, output exp_t e);
    bit         hold, flush, stl, ba, bb;
    logic [1:0] fa, fb;
    int         h;
    longint     maxv;
    e.cfg   = c;
    e.trans = trans_n;
    e.scnt  = m_scnt[c];
    e.fcnt  = m_fcnt[c];
    if (rst) begin
      e.ctrl    = '0;
      rem[c]    = 0;
      m_scnt[c] = 0;
      m_fcnt[c] = 0;
    end else begin
      stl   = (rem[c] > 0);
      hold  = 1'b0;
      flush = 1'b0;
      if (mem_redirect) begin
        flush  = 1'b1;
        rem[c] = 0;
      end else if (rem[c] > 0) begin
        hold   = 1'b1;
        rem[c] = rem[c] - 1;
      end else begin
        h = wait_cycles(c);
        if (h > 0) begin
          hold   = 1'b1;
          rem[c] = h - 1;
        end
      end
      fa = operand_src(c, ex_rs);
      fb = operand_src(c, ex_rt);
      ba = writes(wb_regwr, wb_rw, wb_ovf) && (wb_rw == id_rs);
      bb = writes(wb_regwr, wb_rw, wb_ovf) && id_rt_used && (wb_rw == id_rt);
      e.ctrl = {hold, hold, hold, flush, flush, flush, fa, fb, ba, bb, stl};
      maxv = (longint'(1) << CFG_CW[c]) - 1;
      if (hold && m_scnt[c] < maxv) m_scnt[c] = m_scnt[c] + 1;
      if (mem_redirect && m_fcnt[c] < maxv) m_fcnt[c] = m_fcnt[c] + 1;
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_rt_used = 0; ex_rs = 0; ex_rt = 0; ex_rw = 0;
    ex_regwr = 0; ex_memtoreg = 0; mem_rw = 0; mem_regwr = 0; mem_ovf = 0;
    mem_redirect = 0; wb_rw = 0; wb_regwr = 0; wb_ovf = 0;
  endtask

  // Issue one cycle of stimulus and queue the expected response of every config
  task automatic step();
    exp_t e;
    for (int c = 0; c < NCFG; c++) begin
      model_cycle(c, e);
      sbq.push_back(e);
    end
    $display("trans %0d rst=%0b id=%0d/%0d ex=%0d/%0d rw=%0d mem=%0d wb=%0d redir=%0b",
             trans_n, rst, id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw, mem_redirect);
    trans_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] r);
    clear_inputs();
    ex_rw = r; ex_regwr = 1; ex_memtoreg = 1;
    id_rs = r; id_rt = r; id_rt_used = 1;
  endtask

  // Monitor: outputs are valid every cycle; compare away from the rising edge
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [12:0] got;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = dut_ctrl(e.cfg);
      n_cmp++;
      if (got !== e.ctrl) begin
        n_bad++;
        $display("FAIL ctrl cfg%0d trans %0d: got %b expected %b", e.cfg, e.trans, got, e.ctrl);
      end
      n_cmp++;
      if (dut_scnt(e.cfg) !== e.scnt) begin
        n_bad++;
        $display("FAIL stall_cnt cfg%0d trans %0d: got %0d expected %0d",
                 e.cfg, e.trans, dut_scnt(e.cfg), e.scnt);
      end
      n_cmp++;
      if (dut_fcnt(e.cfg) !== e.fcnt) begin
        n_bad++;
        $display("FAIL flush_cnt cfg%0d trans %0d: got %0d expected %0d",
                 e.cfg, e.trans, dut_fcnt(e.cfg), e.fcnt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    clear_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    // Reset state
    step();
    rst = 0;

    // add $3,$1,$2 ; sub $4,$3,$1
    clear_inputs(); ex_rw = 3; ex_regwr = 1; id_rs = 3; id_rt = 1; id_rt_used = 1; step();
    clear_inputs(); mem_rw = 3; mem_regwr = 1; ex_rs = 3; ex_rt = 1; ex_rw = 4; ex_regwr = 1; step();
    clear_inputs(); repeat (4) step();

    // lw $5,0($0) ; add $6,$5,$5
    load_use(5); step();
    clear_inputs(); mem_rw = 5; mem_regwr = 1; id_rs = 5; id_rt = 5; id_rt_used = 1; step();
    clear_inputs(); wb_rw = 5; wb_regwr = 1; ex_rs = 5; ex_rt = 5; ex_rw = 6; ex_regwr = 1; step();
    clear_inputs(); repeat (4) step();

    // add $3 ; or $7,$3,$0 held in ID while the stall runs
    clear_inputs(); ex_rw = 3; ex_regwr = 1; id_rs = 3; id_rt = 0; id_rt_used = 1;
    repeat (3) step();
    clear_inputs(); repeat (4) step();

    // taken branch resolves while a load-use stall is active
    load_use(8); step();
    clear_inputs(); mem_redirect = 1; step();
    clear_inputs(); repeat (3) step();

    // $0 producers and overflowed producers are ignored
    clear_inputs(); ex_regwr = 1; ex_memtoreg = 1; mem_regwr = 1; wb_regwr = 1; id_rt_used = 1; step();
    clear_inputs(); wb_rw = 9; wb_regwr = 1; wb_ovf = 1; mem_rw = 9; mem_regwr = 1; mem_ovf = 1;
    id_rs = 9; id_rt = 9; id_rt_used = 1; ex_rs = 9; ex_rt = 9; step();
    clear_inputs(); repeat (2) step();

    // reset arrives mid-stall
    load_use(10); step();
    rst = 1; step();
    rst = 0; clear_inputs(); repeat (2) step();

    // randomized traffic over a small register set to provoke many hazards
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rt_used   = 1'($urandom_range(0, 1));
      ex_rs        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      ex_rw        = 5'($urandom_range(0, 3));
      ex_regwr     = ($urandom_range(0, 3) != 0);
      ex_memtoreg  = 1'($urandom_range(0, 1));
      mem_rw       = 5'($urandom_range(0, 3));
      mem_regwr    = ($urandom_range(0, 3) != 0);
      mem_ovf      = ($urandom_range(0, 7) == 0);
      mem_redirect = ($urandom_range(0, 11) == 0);
      wb_rw        = 5'($urandom_range(0, 3));
      wb_regwr     = ($urandom_range(0, 3) != 0);
      wb_ovf       = ($urandom_range(0, 7) == 0);
      step();
    end

    rst = 0; clear_inputs();
    @(negedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
